ac_goto_walker: RTL and testbench
=================================

Name: ac_goto_walker

Overview:
Parametrised Aho-Corasick state-transition engine. Accepts one text character per handshake and walks a runtime-loadable goto table, one entry per cycle. On a miss it follows failure links until a transition hits or the root state is reached. Emits the next automaton state and its match flag. Replaces the fixed 4-entry, hard-coded-character table reader and sits between the text feeder and the match reporter.

Parameters:
STATE_W, 8, width of state numbers
CHAR_W, 8, width of input character
GOTO_DEPTH, 32, number of goto table entries
GOTO_AW, 5, goto table address width (clog2 GOTO_DEPTH)
NSTATES, 32, failure/output table depth; also the failure-hop limit
STATE_AW, 5, failure/output table address width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
CLR  in  1  synchronous soft restart: current state := 0, FSM := IDLE
CHAR_VALID  in  1  character available
CHAR_READY  out  1  high only in IDLE
CHAR_IN  in  CHAR_W  text character
STATE_VALID  out  1  one-cycle pulse, result valid
STATE_OUT  out  STATE_W  new current state
MATCH_OUT  out  1  output-table bit of STATE_OUT
FAIL_ERR  out  1  with STATE_VALID: hop limit hit
BUSY  out  1  FSM not IDLE
TBL_WE  in  1  table write strobe
TBL_SEL  in  2  0=goto, 1=failure, 2=output, 3=invalidate goto entry
TBL_ADDR  in  max(GOTO_AW,STATE_AW)  entry index
TBL_WDATA  in  2*STATE_W+CHAR_W  goto: {cur,char,next}; failure: next in LSBs; output: bit0

Behaviour:
- Reset (RST high, async): state reg, STATE_OUT=0; STATE_VALID, MATCH_OUT, FAIL_ERR, BUSY=0; FSM=IDLE; CHAR_READY=1; all goto valid bits=0. Table data is not reset.
- Goto entry = {valid, cur, char, next}. A TBL_SEL 0 write sets valid=1; a TBL_SEL 3 write clears it.
- Table writes take effect only in IDLE. Writes while BUSY are dropped silently.
- FSM IDLE: on CHAR_VALID&&CHAR_READY at cycle T, latch char, clear idx and hop count, go SCAN.
- FSM SCAN: examine entry idx, starting in cycle T+1.
  - Hit when valid && cur==state && char==latched char: state:=next, go DONE.
  - Miss with idx==GOTO_DEPTH-1 and state==0: state stays 0, go DONE.
  - Miss with idx==GOTO_DEPTH-1 and state!=0: go FAIL.
  - Otherwise idx++.
- FSM FAIL (1 cycle): hop++.
  - If hop reaches NSTATES: state:=0, FAIL_ERR:=1, go DONE.
  - Else: state:=fail[state], idx:=0, go SCAN.
- FSM DONE (1 cycle): STATE_VALID=1, STATE_OUT=state, MATCH_OUT=out[state], go IDLE. CHAR_READY rises the next cycle.
- Latency:
  - Hit at entry i: STATE_VALID in cycle T+2+i.
  - Root miss: T+GOTO_DEPTH+1.
  - Each failure hop adds GOTO_DEPTH+1.
- The first matching entry wins (lowest index) when duplicates exist.
- State values >= NSTATES index fail/out modulo 2^STATE_AW. Software must not load them.
- CLR has priority over all FSM activity. No STATE_VALID is produced for an aborted character.
- RST mid-walk: immediate abort, reset values. Table contents are retained except the valid bits.
- STATE_OUT and MATCH_OUT hold between pulses.

Optional Feature:
AC_MATCH_COUNT_EN:
- Defined: adds output MATCH_CNT[15:0]. It increments on each STATE_VALID with MATCH_OUT=1, saturates at 0xFFFF, and is cleared by RST and CLR.
- Undefined: no port, no counter logic.

Test Plan:
- Load "he" (goto0={0,0x68,1}, goto1={1,0x65,2}, out[2]=1, fail[1]=fail[2]=0). Feed 0x68 at T -> STATE_VALID at T+2, STATE_OUT=1, MATCH_OUT=0.
- Then feed 0x65 at T -> STATE_VALID at T+3, STATE_OUT=2, MATCH_OUT=1 (MATCH_CNT=1 with AC_MATCH_COUNT_EN).
- From state 2, feed 0x78 at T -> one failure hop to 0, STATE_VALID at T+66, STATE_OUT=0, MATCH_OUT=0, FAIL_ERR=0.
- Set fail[1]=1 (self loop). In state 1, feed 0x7A -> after 32 hops STATE_OUT=0, FAIL_ERR=1, single STATE_VALID pulse.
- Write goto0 with next=5 while BUSY -> table unchanged. Re-feed 0x68 from state 0 -> STATE_OUT=1.
- Assert RST, then CLR, each at T+10 of a 0x78 walk -> no STATE_VALID, state 0, CHAR_READY=1 the next cycle. After RST, 0x68 misses (valid bits cleared) -> STATE_OUT=0 at T+33.

Source files
------------

// File: rtl/ac_goto_walker_if.sv
// Character handshake, result and table-load bundle for ac_goto_walker.
// MATCH_CNT exists only when AC_MATCH_COUNT_EN is defined.
interface ac_goto_walker_if #(
  parameter int unsigned STATE_W = 8,
  parameter int unsigned CHAR_W  = 8,
  parameter int unsigned TBL_AW  = 5
);
  localparam int unsigned WD_W = 2 * STATE_W + CHAR_W;

  logic               CLR;
  logic               CHAR_VALID;
  logic               CHAR_READY;
  logic [CHAR_W-1:0]  CHAR_IN;
  logic               STATE_VALID;
  logic [STATE_W-1:0] STATE_OUT;
  logic               MATCH_OUT;
  logic               FAIL_ERR;
  logic               BUSY;
  logic               TBL_WE;
  logic [1:0]         TBL_SEL;
  logic [TBL_AW-1:0]  TBL_ADDR;
  logic [WD_W-1:0]    TBL_WDATA;
`ifdef AC_MATCH_COUNT_EN
  logic [15:0]        MATCH_CNT;
`endif

  modport master (
    output CLR, CHAR_VALID, CHAR_IN, TBL_WE, TBL_SEL, TBL_ADDR, TBL_WDATA,
`ifdef AC_MATCH_COUNT_EN
    input  MATCH_CNT,
`endif
    input  CHAR_READY, STATE_VALID, STATE_OUT, MATCH_OUT, FAIL_ERR, BUSY
  );

  modport slave (
    input  CLR, CHAR_VALID, CHAR_IN, TBL_WE, TBL_SEL, TBL_ADDR, TBL_WDATA,
`ifdef AC_MATCH_COUNT_EN
    output MATCH_CNT,
`endif
    output CHAR_READY, STATE_VALID, STATE_OUT, MATCH_OUT, FAIL_ERR, BUSY
  );
endinterface

// File: rtl/ac_goto_walker.sv
// Aho-Corasick goto/failure walker: one goto entry examined per cycle, failure
// links followed on a miss. Optional AC_MATCH_COUNT_EN adds a saturating match counter.
module ac_goto_walker #(
  parameter int unsigned STATE_W    = 8,
  parameter int unsigned CHAR_W     = 8,
  parameter int unsigned GOTO_DEPTH = 32,
  parameter int unsigned GOTO_AW    = 5,
  parameter int unsigned NSTATES    = 32,
  parameter int unsigned STATE_AW   = 5
) (
  input  logic CLK,
  input  logic RST,
  ac_goto_walker_if.slave bus
);
  localparam int unsigned FT_DEPTH = 1 << STATE_AW;
  localparam int unsigned HOP_W    = $clog2(NSTATES + 1);
  localparam int unsigned WD_W     = 2 * STATE_W + CHAR_W;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FAIL, S_DONE} fsm_t;

  // Table storage: goto valid bits are reset, data arrays are not
  logic [GOTO_DEPTH-1:0] goto_vld;
  logic [STATE_W-1:0]    goto_cur [GOTO_DEPTH];
  logic [CHAR_W-1:0]     goto_chr [GOTO_DEPTH];
  logic [STATE_W-1:0]    goto_nxt [GOTO_DEPTH];
  logic [STATE_W-1:0]    fail_tbl [FT_DEPTH];
  logic [FT_DEPTH-1:0]   out_tbl;

  fsm_t               fsm_q, fsm_n;
  logic [STATE_W-1:0] st_q, st_n;
  logic [CHAR_W-1:0]  chr_q, chr_n;
  logic [GOTO_AW-1:0] idx_q, idx_n;
  logic [HOP_W-1:0]   hop_q, hop_n;
  logic               ferr_n;

  logic               ready_q, busy_q, valid_q, match_q, ferr_q;
  logic [STATE_W-1:0] sout_q;

  logic               tbl_en_c, goto_addr_ok_c, ft_addr_ok_c;
  logic [GOTO_AW-1:0] goto_addr_c;
  logic [STATE_AW-1:0] ft_addr_c;
  logic               hit_c, last_c;

  assign tbl_en_c       = bus.TBL_WE && (fsm_q == S_IDLE);
  assign goto_addr_ok_c = 32'(bus.TBL_ADDR) < GOTO_DEPTH;
  assign ft_addr_ok_c   = 32'(bus.TBL_ADDR) < FT_DEPTH;
  assign goto_addr_c    = GOTO_AW'(bus.TBL_ADDR);
  assign ft_addr_c      = STATE_AW'(bus.TBL_ADDR);

  assign hit_c  = goto_vld[idx_q] && (goto_cur[idx_q] == st_q) && (goto_chr[idx_q] == chr_q);
  assign last_c = (idx_q == GOTO_AW'(GOTO_DEPTH - 1));

  // Goto valid bits: set by a goto write, cleared by an invalidate write
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      goto_vld <= '0;
    end else if (tbl_en_c && goto_addr_ok_c) begin
      if (bus.TBL_SEL == 2'd0) goto_vld[goto_addr_c] <= 1'b1;
      else if (bus.TBL_SEL == 2'd3) goto_vld[goto_addr_c] <= 1'b0;
    end
  end

  // Table data, unaffected by reset
  always_ff @(posedge CLK) begin
    if (tbl_en_c) begin
      case (bus.TBL_SEL)
        2'd0: if (goto_addr_ok_c) begin
          goto_cur[goto_addr_c] <= bus.TBL_WDATA[WD_W-1 -: STATE_W];
          goto_chr[goto_addr_c] <= bus.TBL_WDATA[STATE_W +: CHAR_W];
          goto_nxt[goto_addr_c] <= bus.TBL_WDATA[STATE_W-1:0];
        end
        2'd1: if (ft_addr_ok_c) fail_tbl[ft_addr_c] <= bus.TBL_WDATA[STATE_W-1:0];
        2'd2: if (ft_addr_ok_c) out_tbl[ft_addr_c] <= bus.TBL_WDATA[0];
        default: ;
      endcase
    end
  end

  // Next-state logic; CLR overrides everything
  always_comb begin
    fsm_n  = fsm_q;
    st_n   = st_q;
    chr_n  = chr_q;
    idx_n  = idx_q;
    hop_n  = hop_q;
    ferr_n = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (bus.CHAR_VALID && ready_q) begin
          chr_n = bus.CHAR_IN;
          idx_n = '0;
          hop_n = '0;
          fsm_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (hit_c) begin
          st_n  = goto_nxt[idx_q];
          fsm_n = S_DONE;
        end else if (last_c) begin
          fsm_n = (st_q == '0) ? S_DONE : S_FAIL;
        end else begin
          idx_n = idx_q + GOTO_AW'(1);
        end
      end
      S_FAIL: begin
        hop_n = hop_q + HOP_W'(1);
        if (hop_q == HOP_W'(NSTATES - 1)) begin
          st_n   = '0;
          ferr_n = 1'b1;
          fsm_n  = S_DONE;
        end else begin
          st_n  = fail_tbl[st_q[STATE_AW-1:0]];
          idx_n = '0;
          fsm_n = S_SCAN;
        end
      end
      S_DONE: fsm_n = S_IDLE;
      default: fsm_n = S_IDLE;
    endcase
    if (bus.CLR) begin
      fsm_n  = S_IDLE;
      st_n   = '0;
      ferr_n = 1'b0;
    end
  end

  // State and registered outputs; results update on entry to DONE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q   <= S_IDLE;
      st_q    <= '0;
      chr_q   <= '0;
      idx_q   <= '0;
      hop_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sout_q  <= '0;
      match_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_n;
      st_q    <= st_n;
      chr_q   <= chr_n;
      idx_q   <= idx_n;
      hop_q   <= hop_n;
      ready_q <= (fsm_n == S_IDLE);
      busy_q  <= (fsm_n != S_IDLE);
      valid_q <= (fsm_n == S_DONE);
      ferr_q  <= ferr_n;
      if (fsm_n == S_DONE) begin
        sout_q  <= st_n;
        match_q <= out_tbl[st_n[STATE_AW-1:0]];
      end
    end
  end

  assign bus.CHAR_READY  = ready_q;
  assign bus.BUSY        = busy_q;
  assign bus.STATE_VALID = valid_q;
  assign bus.STATE_OUT   = sout_q;
  assign bus.MATCH_OUT   = match_q;
  assign bus.FAIL_ERR    = ferr_q;

`ifdef AC_MATCH_COUNT_EN
  logic [15:0] cnt_q;

  // Saturating count of matching results
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (bus.CLR) begin
      cnt_q <= '0;
    end else if ((fsm_n == S_DONE) && out_tbl[st_n[STATE_AW-1:0]] && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign bus.MATCH_CNT = cnt_q;
`endif
endmodule

// File: tb/tb_ac_goto_walker.sv
// Directed bench for ac_goto_walker: hits, failure hops, hop limit, busy writes,
// CLR/RST aborts, invalidation and duplicate priority.
module tb_ac_goto_walker;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  logic sv_seen;

  ac_goto_walker_if #(.STATE_W(8), .CHAR_W(8), .TBL_AW(5)) bus ();

  ac_goto_walker #(
    .STATE_W(8), .CHAR_W(8), .GOTO_DEPTH(32), .GOTO_AW(5), .NSTATES(32), .STATE_AW(5)
  ) u_dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tbl_wr(input logic [1:0] sel, input logic [4:0] addr, input logic [23:0] data);
    bus.TBL_WE    = 1'b1;
    bus.TBL_SEL   = sel;
    bus.TBL_ADDR  = addr;
    bus.TBL_WDATA = data;
    tick();
    bus.TBL_WE    = 1'b0;
  endtask

  task automatic start(input logic [7:0] ch);
    bus.CHAR_VALID = 1'b1;
    bus.CHAR_IN    = ch;
    cyc = 0;
    tick();
    bus.CHAR_VALID = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat, input logic [7:0] st,
                           input logic m, input logic fe);
    while (bus.STATE_VALID !== 1'b1 && cyc < 1200) tick();
    check({tag, " valid"}, bus.STATE_VALID, 1'b1);
    check({tag, " latency"}, cyc, lat);
    check({tag, " state"}, bus.STATE_OUT, st);
    check({tag, " match"}, bus.MATCH_OUT, m);
    check({tag, " fail_err"}, bus.FAIL_ERR, fe);
    tick();
    check({tag, " pulse"}, bus.STATE_VALID, 1'b0);
    check({tag, " ready"}, bus.CHAR_READY, 1'b1);
    check({tag, " hold"}, bus.STATE_OUT, st);
  endtask

  task automatic feed(input string tag, input logic [7:0] ch, input int lat,
                      input logic [7:0] st, input logic m, input logic fe);
    start(ch);
    check({tag, " busy"}, bus.BUSY, 1'b1);
    wait_done(tag, lat, st, m, fe);
  endtask

  task automatic watch_quiet(input string tag, input int n);
    sv_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.STATE_VALID === 1'b1) sv_seen = 1'b1;
    end
    check({tag, " no result"}, sv_seen, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    rst = 1'b1;
    bus.CLR = 1'b0;
    bus.CHAR_VALID = 1'b0;
    bus.CHAR_IN = '0;
    bus.TBL_WE = 1'b0;
    bus.TBL_SEL = '0;
    bus.TBL_ADDR = '0;
    bus.TBL_WDATA = '0;
    repeat (3) tick();
    check("rst ready", bus.CHAR_READY, 1'b1);
    check("rst valid", bus.STATE_VALID, 1'b0);
    check("rst state", bus.STATE_OUT, 8'h00);
    check("rst match", bus.MATCH_OUT, 1'b0);
    check("rst ferr", bus.FAIL_ERR, 1'b0);
    check("rst busy", bus.BUSY, 1'b0);
    rst = 1'b0;
    tick();

    // "he" automaton
    tbl_wr(2'd0, 5'd0, {8'h00, 8'h68, 8'h01});
    tbl_wr(2'd0, 5'd1, {8'h01, 8'h65, 8'h02});
    for (int s = 0; s < 4; s++) begin
      tbl_wr(2'd1, 5'(s), 24'h0);
      tbl_wr(2'd2, 5'(s), (s == 2) ? 24'h1 : 24'h0);
    end

    feed("h", 8'h68, 2, 8'h01, 1'b0, 1'b0);
    feed("e", 8'h65, 3, 8'h02, 1'b1, 1'b0);
`ifdef AC_MATCH_COUNT_EN
    check("cnt he", bus.MATCH_CNT, 16'd1);
`endif
    feed("x hop", 8'h78, 66, 8'h00, 1'b0, 1'b0);

    // Self-looping failure link exhausts the hop limit
    tbl_wr(2'd1, 5'd1, 24'h000001);
    feed("h2", 8'h68, 2, 8'h01, 1'b0, 1'b0);
    feed("z limit", 8'h7A, 1057, 8'h00, 1'b0, 1'b1);

    // Goto write during a walk is dropped
    start(8'h78);
    tbl_wr(2'd0, 5'd0, {8'h00, 8'h68, 8'h05});
    check("busy wr busy", bus.BUSY, 1'b1);
    wait_done("root miss", 33, 8'h00, 1'b0, 1'b0);
    feed("h3", 8'h68, 2, 8'h01, 1'b0, 1'b0);

    // CLR abort at T+10 from state 1
    start(8'h78);
    while (cyc < 10) tick();
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    check("clr ready", bus.CHAR_READY, 1'b1);
    check("clr busy", bus.BUSY, 1'b0);
    check("clr valid", bus.STATE_VALID, 1'b0);
    check("clr hold", bus.STATE_OUT, 8'h01);
`ifdef AC_MATCH_COUNT_EN
    check("cnt clr", bus.MATCH_CNT, 16'd0);
`endif
    watch_quiet("clr", 40);
    feed("clr e", 8'h65, 33, 8'h00, 1'b0, 1'b0);

    // RST abort at T+10 from state 1
    feed("h4", 8'h68, 2, 8'h01, 1'b0, 1'b0);
    start(8'h78);
    while (cyc < 10) tick();
    #2 rst = 1'b1;
    #1;
    check("rst2 state", bus.STATE_OUT, 8'h00);
    check("rst2 valid", bus.STATE_VALID, 1'b0);
    check("rst2 ready", bus.CHAR_READY, 1'b1);
    check("rst2 busy", bus.BUSY, 1'b0);
    rst = 1'b0;
    tick();
    check("rst2 ready next", bus.CHAR_READY, 1'b1);
    watch_quiet("rst2", 40);
    feed("rst miss", 8'h68, 33, 8'h00, 1'b0, 1'b0);

    // Duplicate entries: lowest index wins; invalidation exposes the next one
    tbl_wr(2'd0, 5'd0, {8'h00, 8'h68, 8'h01});
    tbl_wr(2'd0, 5'd2, {8'h00, 8'h68, 8'h03});
    tbl_wr(2'd1, 5'd1, 24'h0);
    tbl_wr(2'd1, 5'd3, 24'h0);
    tbl_wr(2'd2, 5'd3, 24'h1);
    feed("dup", 8'h68, 2, 8'h01, 1'b0, 1'b0);
    tbl_wr(2'd3, 5'd0, 24'h0);
    bus.CLR = 1'b1;
    tick();
    bus.CLR = 1'b0;
    feed("inval", 8'h68, 4, 8'h03, 1'b1, 1'b0);
`ifdef AC_MATCH_COUNT_EN
    check("cnt inval", bus.MATCH_CNT, 16'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
